jk_reg_bank: RTL and testbench

//   WIDTH-bit bank of JK flip-flops sharing one clock, each bit with its own J/K pair.

---
 rtl/jk_pkg.sv | 37 +++
 rtl/jk_bit_cell.sv | 25 ++
 rtl/jk_reg_bank.sv | 110 +++++++++++
 tb/tb_jk_reg_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank: JK input encodings, the single-bit
// JK next-state function and a population count helper.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Widest vector popcount accepts; callers zero-extend their vector to this width
    localparam int POP_MAX_W = 256;
    localparam int POP_RES_W = 9;

    // Next value of a single JK bit given its current value and its J/K pair
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            JK_HOLD: nxt = q;
            JK_RST:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

    // Number of set bits in vec
    function automatic logic [POP_RES_W-1:0] popcount(input logic [POP_MAX_W-1:0] vec);
        logic [POP_RES_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            sum = sum + POP_RES_W'(vec[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/jk_bit_cell.sv
// One bit of the JK register bank: combinational next state with priority
// load > en > hold.
module jk_bit_cell
    import jk_pkg::*;
(
    input  logic q,
    input  logic j,
    input  logic k,
    input  logic en,
    input  logic load,
    input  logic d,
    output logic q_d
);

    // Select parallel load, the JK rule, or hold for this bit
    always_comb begin
        q_d = q;
        if (load) begin
            q_d = d;
        end else if (en) begin
            q_d = jk_next(q, j, k);
        end
    end

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK flip-flops with parallel load, global enable, a one-cycle
// change flag and an optional saturating bit-change counter.
// Optional feature macro: JK_CHG_CNT_EN (adds the tgl_cnt port and counter).
// WIDTH must not exceed jk_pkg::POP_MAX_W.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             changed
`ifdef JK_CHG_CNT_EN
    ,
    output logic [CNT_W-1:0] tgl_cnt
`endif
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             changed_q;
    logic             changed_d;
    logic [WIDTH-1:0] diff;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_bit_cell u_cell (
                .q    (state_q[gi]),
                .j    (j[gi]),
                .k    (k[gi]),
                .en   (en),
                .load (load),
                .d    (d[gi]),
                .q_d  (state_d[gi])
            );
        end
    endgenerate

    // Bits that flip on this edge and whether any of them does
    always_comb begin
        diff      = state_d ^ state_q;
        changed_d = |diff;
    end

    // State register and change flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_VAL;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            changed_q <= changed_d;
        end
    end

    assign q       = state_q;
    assign qb      = ~state_q;
    assign changed = changed_q;

`ifdef JK_CHG_CNT_EN
    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [POP_W-1:0] pop_cnt;
    logic [SUM_W-1:0] sum;

    // Saturating add of this edge's bit-change count; clear wins and drops the increment
    always_comb begin
        pop_cnt = POP_W'(popcount(POP_MAX_W'(diff)));
        sum     = SUM_W'(cnt_q) + SUM_W'(pop_cnt);
        cnt_d   = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (sum > SUM_W'({CNT_W{1'b1}})) begin
            cnt_d = {CNT_W{1'b1}};
        end else begin
            cnt_d = CNT_W'(sum);
        end
    end

    // Bit-change counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tgl_cnt = cnt_q;
`else
    // Counter is not built; cnt_clr is accepted and ignored
    logic [CNT_W-1:0] unused_cnt_clr;
    assign unused_cnt_clr = {CNT_W{cnt_clr}};
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank (WIDTH=4, RESET_VAL=0, CNT_W=4).
// Counter checks are included when JK_CHG_CNT_EN is defined.
module tb_jk_reg_bank;

   localparam int WIDTH   = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             load;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             cnt_clr;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic             changed;
`ifdef JK_CHG_CNT_EN
   logic [CNT_W-1:0] tgl_cnt;
`endif

   int nChecks = 0;
   int nFails  = 0;

   // Behavioural reference state
   logic [WIDTH-1:0] mQ;
   logic             mChg;
   int               mCnt;

   typedef struct {
      string            name;
      logic             load;
      logic             en;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] j;
      logic [WIDTH-1:0] k;
      logic             clr;
      logic [WIDTH-1:0] expQ;
      logic             expChg;
      int               expCnt;
   } vec_t;

   vec_t vecs[15];

   jk_reg_bank #(
      .WIDTH     (WIDTH),
      .RESET_VAL (4'b0000),
      .CNT_W     (CNT_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .load    (load),
      .d       (d),
      .j       (j),
      .k       (k),
      .cnt_clr (cnt_clr),
      .q       (q),
      .qb      (qb),
      .changed (changed)
`ifdef JK_CHG_CNT_EN
      ,
      .tgl_cnt (tgl_cnt)
`endif
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one set of inputs at the falling edge, let one rising edge pass, advance the model
   task automatic applyStimulus(input logic l, input logic e, input logic [WIDTH-1:0] dd,
                                input logic [WIDTH-1:0] jj, input logic [WIDTH-1:0] kk,
                                input logic c);
      logic [WIDTH-1:0] nxt;
      int               sum;
      @(negedge clk);
      load    = l;
      en      = e;
      d       = dd;
      j       = jj;
      k       = kk;
      cnt_clr = c;
      @(posedge clk);
      #1;
      if (l)
         nxt = dd;
      else if (e)
         nxt = (mQ & ~kk) | (~mQ & jj);
      else
         nxt = mQ;
      sum  = mCnt + $countones(nxt ^ mQ);
      mCnt = c ? 0 : ((sum > CNT_MAX) ? CNT_MAX : sum);
      mChg = (nxt != mQ);
      mQ   = nxt;
   endtask

   // Compare every output against the supplied expectation
   task automatic checkOutput(input string name, input logic [WIDTH-1:0] expQ,
                              input logic expChg, input int expCnt);
      nChecks++;
      if (q !== expQ) begin
         nFails++;
         $display("[TB] FAIL %s q: got %b expected %b", name, q, expQ);
      end
      nChecks++;
      if (qb !== ~expQ) begin
         nFails++;
         $display("[TB] FAIL %s qb: got %b expected %b", name, qb, ~expQ);
      end
      nChecks++;
      if (changed !== expChg) begin
         nFails++;
         $display("[TB] FAIL %s changed: got %b expected %b", name, changed, expChg);
      end
`ifdef JK_CHG_CNT_EN
      nChecks++;
      if (tgl_cnt !== CNT_W'(expCnt)) begin
         nFails++;
         $display("[TB] FAIL %s tgl_cnt: got %0d expected %0d", name, tgl_cnt, expCnt);
      end
`endif
   endtask

   initial begin
      //             name           load  en    d        j        k        clr   q        chg   cnt
      vecs[0]  = '{"idle0",        1'b0, 1'b0, 4'h0,    4'h0,    4'h0,    1'b0, 4'b0000, 1'b0, 0};
      vecs[1]  = '{"idle_jk",      1'b0, 1'b0, 4'h0,    4'hF,    4'hF,    1'b0, 4'b0000, 1'b0, 0};
      vecs[2]  = '{"idle_d",       1'b0, 1'b0, 4'hA,    4'h0,    4'h0,    1'b0, 4'b0000, 1'b0, 0};
      vecs[3]  = '{"jk_modes",     1'b0, 1'b1, 4'h0,    4'b1010, 4'b0110, 1'b0, 4'b1010, 1'b1, 2};
      vecs[4]  = '{"jk_toggle",    1'b0, 1'b1, 4'h0,    4'hF,    4'hF,    1'b0, 4'b0101, 1'b1, 6};
      vecs[5]  = '{"en_hold",      1'b0, 1'b1, 4'h0,    4'h0,    4'h0,    1'b0, 4'b0101, 1'b0, 6};
      vecs[6]  = '{"load_prio",    1'b1, 1'b1, 4'b0110, 4'hF,    4'hF,    1'b0, 4'b0110, 1'b1, 8};
      vecs[7]  = '{"reload_same",  1'b1, 1'b0, 4'b0110, 4'h0,    4'h0,    1'b0, 4'b0110, 1'b0, 8};
      vecs[8]  = '{"rst_on_zero",  1'b0, 1'b1, 4'h0,    4'b0000, 4'b0001, 1'b0, 4'b0110, 1'b0, 8};
      vecs[9]  = '{"tgl_a",        1'b0, 1'b1, 4'h0,    4'hF,    4'hF,    1'b0, 4'b1001, 1'b1, 12};
      vecs[10] = '{"tgl_clamp",    1'b0, 1'b1, 4'h0,    4'hF,    4'hF,    1'b0, 4'b0110, 1'b1, 15};
      vecs[11] = '{"tgl_sat",      1'b0, 1'b1, 4'h0,    4'hF,    4'hF,    1'b0, 4'b1001, 1'b1, 15};
      vecs[12] = '{"clr_tgl",      1'b0, 1'b1, 4'h0,    4'hF,    4'hF,    1'b1, 4'b0110, 1'b1, 0};
      vecs[13] = '{"clr_idle",     1'b0, 1'b0, 4'h0,    4'h0,    4'h0,    1'b1, 4'b0110, 1'b0, 0};
      vecs[14] = '{"jk_set",       1'b0, 1'b1, 4'h0,    4'hF,    4'h0,    1'b0, 4'b1111, 1'b1, 2};

      rst_n   = 1'b0;
      en      = 1'b0;
      load    = 1'b0;
      d       = '0;
      j       = '0;
      k       = '0;
      cnt_clr = 1'b0;
      mQ      = '0;
      mChg    = 1'b0;
      mCnt    = 0;

      #3;
      checkOutput("reset", 4'b0000, 1'b0, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_held", 4'b0000, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].load, vecs[i].en, vecs[i].d, vecs[i].j, vecs[i].k, vecs[i].clr);
         checkOutput(vecs[i].name, vecs[i].expQ, vecs[i].expChg, vecs[i].expCnt);
      end

      // Asynchronous reset between edges while q=1111
      @(negedge clk);
      en      = 1'b0;
      load    = 1'b0;
      j       = '0;
      k       = '0;
      cnt_clr = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst", 4'b0000, 1'b0, 0);
      @(posedge clk);
      #1;
      checkOutput("async_held", 4'b0000, 1'b0, 0);
      mQ   = '0;
      mChg = 1'b0;
      mCnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 4'b1011, 4'h0, 4'h0, 1'b0);
      checkOutput("first_after_rst", 4'b1011, 1'b1, 3);

      // Randomised traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                       4'($urandom), 4'($urandom), 4'($urandom),
                       ($urandom_range(0, 7) == 0));
         checkOutput("random", mQ, mChg, mCnt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
